backscatter_tx_scheduler: RTL and testbench

Sequences one backscatter packet through the tag's modulator path. After a start request, it waits for an excitation-detect indication and then drives `trigger_signal` to enable the modulator. It emits a fixed preamble, then streams payload bits from an upstream bit source, one bit per symbol period, as a phase-flip control (bit 1 flips phase, bit 0 holds it). The block sits between the packet/bit-source logic and the modulator, and owns all packet-level timing: preamble, payload, timeout, underrun and inter-packet gap.

---
 rtl/backscatter_tx_scheduler_pkg.sv | 7 +
 rtl/backscatter_tx_scheduler_symbol_timer.sv | 20 ++
 rtl/backscatter_tx_scheduler.sv | 112 +++++++++++
 tb/tb_backscatter_tx_scheduler.sv | 240 ++++++++++++++++++++++++
 4 files changed

// File: rtl/backscatter_tx_scheduler_pkg.sv
// backscatter_tx_scheduler_pkg: shared state encoding and counter width helper
package backscatter_tx_scheduler_pkg;
   typedef enum logic [2:0] {IDLE, ARM, PREAMBLE, DATA, GAP} state_t;
   function automatic int cnt_width(input int n);
      return (n < 2) ? 1 : $clog2(n);
   endfunction
endpackage

// File: rtl/backscatter_tx_scheduler_symbol_timer.sv
// backscatter_tx_scheduler_symbol_timer: modulo-SYMBOL_CYCLES counter with symbol start/end strobes
module backscatter_tx_scheduler_symbol_timer
   import backscatter_tx_scheduler_pkg::*;
#(
   parameter int SYMBOL_CYCLES = 80
)(
   input  logic clock,
   input  logic reset,
   input  logic clear,
   output logic sym_start,
   output logic sym_end
);
   localparam int W = cnt_width(SYMBOL_CYCLES);
   logic [W-1:0] count;
   assign sym_start = (count == '0);
   assign sym_end = (count == W'(SYMBOL_CYCLES - 1));
   // Symbol phase counter, held at zero while cleared so a packet starts on a symbol boundary
   always_ff @(posedge clock)
      count <= (reset || clear || sym_end) ? '0 : count + 1'b1;
endmodule

// File: rtl/backscatter_tx_scheduler.sv
// backscatter_tx_scheduler: packet sequencer for the backscatter modulator (arm, preamble, payload, gap)
module backscatter_tx_scheduler
   import backscatter_tx_scheduler_pkg::*;
#(
   parameter int SYMBOL_CYCLES    = 80,
   parameter int PREAMBLE_SYMBOLS = 8,
   parameter int GAP_CYCLES       = 200,
   parameter int TIMEOUT_CYCLES   = 60000,
   parameter int LEN_W            = 12
)(
   input  logic             clock,
   input  logic             reset,
   input  logic             start,
   input  logic [LEN_W-1:0] packet_len,
   input  logic             excite_detect,
   input  logic             abort,
   input  logic             bit_valid,
   input  logic             bit_data,
   output logic             bit_ready,
   output logic             trigger_signal,
   output logic             mod_phase,
   output logic             busy,
   output logic             done,
   output logic             error
);
   localparam int WAIT_MAX = (TIMEOUT_CYCLES > GAP_CYCLES) ? TIMEOUT_CYCLES : GAP_CYCLES;
   localparam int CNT_W = cnt_width((WAIT_MAX > PREAMBLE_SYMBOLS + 1) ? WAIT_MAX : PREAMBLE_SYMBOLS + 1);
   state_t state;
   logic [CNT_W-1:0] cnt;
   logic [LEN_W-1:0] len, bit_cnt;
   logic err_seen, sym_start, sym_end, fetch, last;
   backscatter_tx_scheduler_symbol_timer #(.SYMBOL_CYCLES(SYMBOL_CYCLES)) u_timer (
      .clock(clock),
      .reset(reset),
      .clear(state != PREAMBLE && state != DATA),
      .sym_start(sym_start),
      .sym_end(sym_end)
   );
   // A payload bit is fetched at the end of the last preamble symbol and of every non-final data symbol
   assign fetch = sym_end && ((state == PREAMBLE && cnt == CNT_W'(PREAMBLE_SYMBOLS)) || (state == DATA && bit_cnt != len));
   assign last = sym_end && state == DATA && bit_cnt == len;
   // Packet FSM; cnt serves as timeout counter in ARM, symbol counter in PREAMBLE, gap counter in GAP
   always_ff @(posedge clock) begin
      if (reset) begin
         state <= IDLE;
         cnt <= '0;
         len <= '0;
         bit_cnt <= '0;
         err_seen <= 1'b0;
         bit_ready <= 1'b0;
         trigger_signal <= 1'b0;
         mod_phase <= 1'b0;
         busy <= 1'b0;
         done <= 1'b0;
         error <= 1'b0;
      end else begin
         bit_ready <= 1'b0;
         done <= 1'b0;
         error <= 1'b0;
         if (abort && state != IDLE) begin
            state <= IDLE;
            trigger_signal <= 1'b0;
            mod_phase <= 1'b0;
            busy <= 1'b0;
         end else begin
            case (state)
               IDLE: if (start && packet_len != '0) begin
                  state <= ARM;
                  len <= packet_len;
                  bit_cnt <= '0;
                  cnt <= '0;
                  err_seen <= 1'b0;
                  busy <= 1'b1;
               end
               ARM: if (excite_detect) begin
                  state <= PREAMBLE;
                  trigger_signal <= 1'b1;
                  mod_phase <= 1'b0;
                  cnt <= '0;
               end else if (cnt == CNT_W'(TIMEOUT_CYCLES - 1)) begin
                  state <= IDLE;
                  busy <= 1'b0;
                  error <= 1'b1;
               end else cnt <= cnt + 1'b1;
               PREAMBLE, DATA: begin
                  if (state == PREAMBLE && sym_start) cnt <= cnt + 1'b1;
                  if (state == PREAMBLE && sym_end && cnt != CNT_W'(PREAMBLE_SYMBOLS)) mod_phase <= ~mod_phase;
                  if (fetch && bit_valid) begin
                     state <= DATA;
                     bit_ready <= 1'b1;
                     mod_phase <= mod_phase ^ bit_data;
                     bit_cnt <= bit_cnt + 1'b1;
                  end else if (fetch || last) begin
                     state <= GAP;
                     trigger_signal <= 1'b0;
                     mod_phase <= 1'b0;
                     cnt <= '0;
                     error <= fetch;
                     err_seen <= fetch;
                  end
               end
               GAP: if (cnt == CNT_W'(GAP_CYCLES - 1)) begin
                  state <= IDLE;
                  busy <= 1'b0;
                  done <= ~err_seen;
               end else cnt <= cnt + 1'b1;
               default: state <= IDLE;
            endcase
         end
      end
   end
endmodule

// File: tb/tb_backscatter_tx_scheduler.sv
// tb_backscatter_tx_scheduler: directed scoreboard bench for the backscatter packet scheduler
module tb_backscatter_tx_scheduler;
   localparam int SC  = 6;
   localparam int PRE = 8;
   localparam int GAP = 20;
   localparam int TO  = 1000;
   localparam int LW  = 12;

   logic clock = 1'b0;
   logic reset = 1'b1;
   logic start = 1'b0;
   logic [LW-1:0] packet_len = '0;
   logic excite_detect = 1'b0;
   logic abort = 1'b0;
   logic bit_valid = 1'b0;
   logic bit_data = 1'b0;
   logic bit_ready, trigger_signal, mod_phase, busy, done, error;

   int checks = 0;
   int failures = 0;
   int cyc = 0;
   bit src_q[$];
   bit exp_q[$];
   bit ph_model;
   int trig_cycles, ready_cnt, done_cnt, err_cnt, last_ready, first_ready, err_cyc, done_cyc;
   int n0, m0;

   backscatter_tx_scheduler #(
      .SYMBOL_CYCLES(SC),
      .PREAMBLE_SYMBOLS(PRE),
      .GAP_CYCLES(GAP),
      .TIMEOUT_CYCLES(TO),
      .LEN_W(LW)
   ) dut (
      .clock(clock),
      .reset(reset),
      .start(start),
      .packet_len(packet_len),
      .excite_detect(excite_detect),
      .abort(abort),
      .bit_valid(bit_valid),
      .bit_data(bit_data),
      .bit_ready(bit_ready),
      .trigger_signal(trigger_signal),
      .mod_phase(mod_phase),
      .busy(busy),
      .done(done),
      .error(error)
   );

   always #5 clock = ~clock;

   always @(posedge clock) cyc <= cyc + 1;

   task automatic chk(input string tag, input int obs, input int exp_v);
      checks++;
      assert (obs === exp_v) else begin
         failures++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp_v);
      end
   endtask

   task automatic step();
      @(negedge clock);
      #1;
   endtask

   task automatic new_packet();
      src_q.delete();
      exp_q.delete();
      ph_model = ((PRE - 1) % 2) != 0;
      trig_cycles = 0;
      ready_cnt = 0;
      done_cnt = 0;
      err_cnt = 0;
      last_ready = -1;
      first_ready = -1;
      err_cyc = -1;
      done_cyc = -1;
   endtask

   task automatic push_bit(input bit b);
      src_q.push_back(b);
      ph_model = ph_model ^ b;
      exp_q.push_back(ph_model);
   endtask

   task automatic pulse_start(input int len);
      packet_len = len[LW-1:0];
      start = 1'b1;
      step();
      start = 1'b0;
   endtask

   task automatic excite();
      excite_detect = 1'b1;
      step();
      excite_detect = 1'b0;
   endtask

   function automatic int outs();
      return int'({trigger_signal, mod_phase, busy, bit_ready, done, error});
   endfunction

   // Output monitor and upstream bit source: scoreboard pops on each bit_ready
   always @(negedge clock) begin
      if (trigger_signal) trig_cycles++;
      if (done) begin done_cnt++; done_cyc = cyc; end
      if (error) begin err_cnt++; err_cyc = cyc; end
      if (bit_ready) begin
         ready_cnt++;
         if (first_ready < 0) first_ready = cyc;
         if (last_ready >= 0) chk("ready_spacing", cyc - last_ready, SC);
         last_ready = cyc;
         if (exp_q.size() == 0) chk("unexpected_ready", ready_cnt, 0);
         else chk("data_phase", int'(mod_phase), int'(exp_q.pop_front()));
         if (src_q.size() != 0) void'(src_q.pop_front());
      end
      bit_valid = src_q.size() != 0;
      bit_data = (src_q.size() != 0) ? src_q[0] : 1'b0;
   end

   initial begin
      new_packet();
      repeat (3) step();
      chk("reset_outputs", outs(), 0);
      reset = 1'b0;
      step();
      // Nominal packet: bits 1,0,1,1 -> phases 0,0,1,0
      new_packet();
      push_bit(1'b1); push_bit(1'b0); push_bit(1'b1); push_bit(1'b1);
      pulse_start(4);
      chk("busy_after_start", int'(busy), 1);
      repeat (4) step();
      chk("arm_no_trigger", int'(trigger_signal), 0);
      excite();
      m0 = cyc;
      chk("trigger_rise", int'(trigger_signal), 1);
      for (int k = 0; k < PRE; k++) begin
         chk("pre_phase", int'(mod_phase), k % 2);
         repeat (SC) step();
      end
      for (int i = 0; i < 6 * SC && trigger_signal; i++) step();
      chk("trig_fall", int'(trigger_signal), 0);
      chk("trig_fall_time", cyc - m0, (PRE + 4) * SC);
      chk("trig_cycles", trig_cycles, (PRE + 4) * SC);
      chk("first_ready", first_ready - m0, PRE * SC);
      chk("ready_count", ready_cnt, 4);
      chk("sb_empty", exp_q.size(), 0);
      chk("gap_phase", int'(mod_phase), 0);
      repeat (3) step();
      pulse_start(4);
      chk("busy_in_gap", int'(busy), 1);
      for (int i = 0; i < GAP + 10 && done_cnt == 0; i++) step();
      chk("done_count", done_cnt, 1);
      chk("done_time", done_cyc - m0, (PRE + 4) * SC + GAP);
      chk("busy_falls_with_done", int'(busy), 0);
      chk("nominal_no_error", err_cnt, 0);
      repeat (3) step();
      chk("start_not_queued", int'(busy), 0);
      pulse_start(0);
      chk("len0_ignored", outs(), 0);
      // Timeout with no excitation
      new_packet();
      pulse_start(3);
      n0 = cyc;
      for (int i = 0; i < TO + 10 && err_cnt == 0; i++) step();
      chk("timeout_err", err_cnt, 1);
      chk("timeout_time", err_cyc - n0, TO);
      chk("timeout_no_trigger", trig_cycles, 0);
      chk("timeout_idle", int'(busy), 0);
      // Excitation on the timeout cycle wins, then reset in preamble
      new_packet();
      pulse_start(3);
      repeat (TO - 1) step();
      excite();
      chk("excite_wins", int'(trigger_signal), 1);
      chk("excite_no_error", err_cnt, 0);
      repeat (SC + 1) step();
      chk("in_preamble", int'(trigger_signal), 1);
      reset = 1'b1;
      step();
      reset = 1'b0;
      chk("reset_in_pre", outs(), 0);
      pulse_start(2);
      chk("start_after_reset", int'(busy), 1);
      abort = 1'b1;
      step();
      abort = 1'b0;
      chk("abort_in_arm", outs(), 0);
      // Underrun before the third of six bits
      new_packet();
      push_bit(1'b1); push_bit(1'b1);
      pulse_start(6);
      step();
      excite();
      m0 = cyc;
      for (int i = 0; i < (PRE + 8) * SC && err_cnt == 0; i++) step();
      chk("underrun_err", err_cnt, 1);
      chk("underrun_time", err_cyc - m0, (PRE + 2) * SC);
      chk("underrun_trig", int'(trigger_signal), 0);
      chk("underrun_ready", ready_cnt, 2);
      repeat (GAP - 1) step();
      chk("underrun_gap_busy", int'(busy), 1);
      step();
      chk("underrun_idle", int'(busy), 0);
      chk("underrun_no_done", done_cnt, 0);
      // Abort during DATA
      new_packet();
      for (int i = 0; i < 5; i++) push_bit(1'($urandom_range(0, 1)));
      pulse_start(5);
      excite();
      for (int i = 0; i < (PRE + 4) * SC && ready_cnt < 2; i++) step();
      chk("abort_reached_data", ready_cnt, 2);
      abort = 1'b1;
      step();
      abort = 1'b0;
      chk("abort_in_data", outs(), 0);
      new_packet();
      pulse_start(1);
      chk("start_after_abort", int'(busy), 1);
      abort = 1'b1;
      step();
      abort = 1'b0;
      step();
      // Maximum length packet
      new_packet();
      for (int i = 0; i < 4095; i++) push_bit(1'($urandom_range(0, 1)));
      pulse_start(4095);
      step();
      excite();
      for (int i = 0; i < (PRE + 4095) * SC + GAP + 20 && done_cnt == 0; i++) step();
      chk("max_done", done_cnt, 1);
      chk("max_ready", ready_cnt, 4095);
      chk("max_sb_empty", exp_q.size(), 0);
      chk("max_no_error", err_cnt, 0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
